// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl_pkg
// Description : Shared types for the RAM-backed FIFO controller.
//               cnt_op_e selects how the occupancy register moves in a cycle.
//               cnt_op() derives it from the accepted push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A push and a pop in the same cycle cancel out.
    // The occupancy only moves when exactly one of them is accepted.
    function automatic cnt_op_e cnt_op(input logic push_ok, input logic pop_ok);
        cnt_op_e op;
        op = CNT_HOLD;
        if (push_ok && !pop_ok) begin
            op = CNT_INC;
        end else if (pop_ok && !push_ok) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl_if
// Description : Bundle of all FIFO controller signals, excluding clk and rst_n.
//               It covers the producer/consumer side and the RAM side.
//               - slave  : used by the controller.
//               - master : used by the surrounding logic, i.e. the
//                          producer, the consumer and the RAM.
//               Port summary:
//               - push/din/pop                          : requests
//               - dout/dout_valid                        : read data
//               - full/empty/almost_full/count           : status
//               - overflow/underflow                     : sticky errors
//               - ram_we/ram_waddr/ram_raddr/ram_wdata   : to the RAM
//               - ram_rdata                              : from the RAM
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) ();
    logic                  push;
    logic [DATA_WIDTH-1:0] din;
    logic                  pop;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  push, din, pop, ram_rdata,
        output dout, dout_valid, full, empty, almost_full, count,
               overflow, underflow, ram_we, ram_waddr, ram_raddr, ram_wdata
    );

    modport master (
        output push, din, pop, ram_rdata,
        input  dout, dout_valid, full, empty, almost_full, count,
               overflow, underflow, ram_we, ram_waddr, ram_raddr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : FIFO pointer register with increment-and-wrap.
//               The MSB is the wrap bit.
//               The pointer wraps modulo 2^PTR_W.
//               Port summary:
//               - clk, rst_n : clock; synchronous active-low reset
//               - inc_i      : advance the pointer by one
//               - ptr_o      : current (registered) pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int PTR_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc_i,
    output logic      [PTR_W-1:0] ptr_o
);
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Natural binary overflow provides the wrap.
    // The low bits return to 0 and the MSB toggles.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Turns a simple dual-port RAM into a push/pop FIFO.
//               The RAM has a 1-cycle registered read and is read-first
//               on a same-address collision.
//               This block owns the RAM write port and the RAM read address.
//               Port summary:
//               - clk, rst_n : clock; synchronous active-low reset
//               - bus        : ram_fifo_ctrl_if.slave
//                              (requests, status, errors, RAM port)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 7,
    parameter int AFULL_LEVEL = 120
) (
    input wire logic          clk,
    input wire logic          rst_n,
    ram_fifo_ctrl_if.slave    bus
);
    localparam int               DEPTH     = 1 << ADDR_WIDTH;
    localparam int               PTR_W     = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  dout_valid_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty, full, pop_ok, push_ok;
    logic [DATA_WIDTH-1:0] rdata;
    cnt_op_e               op;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // When full, a push is accepted only together with an accepted pop.
    // In that case both pointers address the same slot. The RAM's
    // read-first behaviour returns the old word, and the new word then
    // overwrites the slot.
    assign pop_ok  = bus.pop && !empty;
    assign push_ok = bus.push && (!full || pop_ok);
    assign op      = cnt_op(push_ok, pop_ok);

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (push_ok),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (pop_ok),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q  || (bus.push && !push_ok);
        underflow_d = underflow_q || (bus.pop && empty);
        case (op)
            CNT_INC: count_d = count_q + PTR_W'(1);
            CNT_DEC: count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A pop accepted just before reset is dropped here.
    // Stale RAM read data therefore never surfaces as valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_valid_q <= pop_ok;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // RAM addresses come from the current pointers, not the next ones.
    // The word read for a pop is therefore the one the pop accepted.
    assign bus.ram_we      = push_ok && rst_n;
    assign bus.ram_waddr   = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.ram_raddr   = rd_ptr[ADDR_WIDTH-1:0];
    assign bus.ram_wdata   = bus.din;

    assign rdata           = bus.ram_rdata;
    assign bus.dout        = rdata;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count_q >= AFULL_THR);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

    // DEPTH documents the legal occupancy range; count_q never exceeds it.
    logic unused_depth;
    assign unused_depth = (DEPTH == 0);
endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Self-checking bench for ram_fifo_ctrl.
//               Includes a simple dual-port RAM model (registered read,
//               read-first) and a queue-based reference FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int AFULL = 120;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_fifo_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: the nonblocking read sees the old word on a same-address write.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_raddr];
    end

    // Reference model
    logic [DW-1:0] q[$];
    logic          m_valid;
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_unf;
    int            m_wr, m_rd;   // accepted pushes/pops since reset

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at the negedge, check ram_we before the edge,
    // advance the model at the edge, and check the outputs #1 later.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic r, input logic rn);
        logic pop_ok, push_ok;
        bus.push = p; bus.din = d; bus.pop = r; rst_n = rn;
        #1;
        pop_ok  = r && (q.size() > 0);
        push_ok = p && ((q.size() < DEPTH) || pop_ok);
        check_eq("ram_we", bus.ram_we, rn && push_ok);
        if (rn && push_ok) begin
            check_eq("ram_wdata", bus.ram_wdata, d);
            check_eq("ram_waddr", bus.ram_waddr, m_wr % DEPTH);
        end
        if (rn && pop_ok) check_eq("ram_raddr", bus.ram_raddr, m_rd % DEPTH);
        @(posedge clk);
        if (!rn) begin
            q.delete(); m_valid = 0; m_ovf = 0; m_unf = 0; m_wr = 0; m_rd = 0;
        end else begin
            m_valid = pop_ok;
            if (pop_ok) begin m_dout = q.pop_front(); m_rd++; end
            if (push_ok) begin q.push_back(d); m_wr++; end
            if (p && !push_ok) m_ovf = 1;
            if (r && !pop_ok && !(q.size() > 0 && push_ok && !pop_ok && q.size() == 1 && 0)) begin
                if (!pop_ok) m_unf = 1;
            end
        end
        #1;
        check_eq("count",       bus.count, q.size());
        check_eq("empty",       bus.empty, q.size() == 0);
        check_eq("full",        bus.full, q.size() == DEPTH);
        check_eq("almost_full", bus.almost_full, q.size() >= AFULL);
        check_eq("overflow",    bus.overflow, m_ovf);
        check_eq("underflow",   bus.underflow, m_unf);
        check_eq("dout_valid",  bus.dout_valid, m_valid);
        if (m_valid) check_eq("dout", bus.dout, m_dout);
        @(negedge clk);
    endtask

    initial begin
        q.delete(); m_valid = 0; m_dout = '0; m_ovf = 0; m_unf = 0; m_wr = 0; m_rd = 0;
        bus.push = 0; bus.din = '0; bus.pop = 0; rst_n = 0;
        @(negedge clk);

        // Reset then idle; push held high to show ram_we is forced low
        step(1, 16'h5555, 0, 0);
        step(0, 16'h0, 0, 0);
        step(0, 16'h0, 0, 1);

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 1, 1);
        step(0, 16'h0, 0, 1);

        // Fall-through, then repeated single-word pairs across two wraps
        step(1, 16'hBEEF, 0, 1);
        step(0, 16'h0, 1, 1);
        step(0, 16'h0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            step(1, DW'($urandom), 0, 1);
            step(0, 16'h0, 1, 1);
        end

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1, 16'h1000 + DW'(i), 0, 1);
        step(1, 16'hAAAA, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 1, 1);
        step(0, 16'h0, 0, 1);

        // Error flags: empty push+pop, pop when empty, push when full
        step(1, 16'h7777, 1, 1);
        step(0, 16'h0, 1, 1);
        step(0, 16'h0, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, 1);
        step(1, 16'hDEAD, 0, 1);
        step(0, 16'h0, 0, 1);
        step(0, 16'h0, 0, 0);
        step(0, 16'h0, 0, 1);

        // Reset mid-stream
        for (int i = 0; i < 50; i++) step(1, DW'($urandom), 0, 1);
        step(0, 16'h0, 1, 1);
        step(0, 16'h0, 0, 0);
        step(1, 16'h1234, 0, 1);
        step(0, 16'h0, 1, 1);
        step(0, 16'h0, 0, 1);

        // Randomized traffic with phases biased toward filling and draining
        for (int i = 0; i < 4000; i++) begin
            int bias;
            bias = ((i / 500) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < bias, DW'($urandom),
                 $urandom_range(0, 99) < (100 - bias),
                 $urandom_range(0, 199) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
